// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares a single adder/subtractor among N requesters.
// Operations time out after TIMEOUT wait cycles and report err with result 0.
module alu_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [16*N-1:0] op_a,
    input  logic [16*N-1:0] op_b,
    input  logic [N-1:0]    op_sub,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [15:0]     result,
    output logic            err,
    output logic            busy,
    output logic [15:0]     alu_in1,
    output logic [15:0]     alu_in2,
    output logic            alu_sub,
    output logic            alu_start,
    input  logic [15:0]     alu_out,
    input  logic            alu_finish,
    output logic [15:0]     op_count
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     in1_q, in1_d;
    logic [15:0]     in2_q, in2_d;
    logic            sub_q, sub_d;
    logic [15:0]     result_q, result_d;
    logic            err_q, err_d;
    logic [15:0]     op_count_q, op_count_d;

    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] win_idx;
    logic            win_found;
    logic [N-1:0]    idx_onehot;

    // Search ascends from the requester after the last one served, wrapping at N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= int'(N); k++) begin
            cand = IdxW'((int'(last_q) + k) % int'(N));
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        sub_d      = sub_q;
        result_d   = result_q;
        err_d      = err_q;
        op_count_d = op_count_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    in1_d   = op_a[16*win_idx +: 16];
                    in2_d   = op_b[16*win_idx +: 16];
                    sub_d   = op_sub[win_idx];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A finish arriving on the timeout cycle still counts as success.
                if (alu_finish) begin
                    result_d = alu_out;
                    err_d    = 1'b0;
                    state_d  = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                last_d = idx_q;
                if (!err_q && op_count_q != 16'hFFFF) begin
                    op_count_d = op_count_q + 16'd1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            last_q     <= IdxW'(N - 1);
            cnt_q      <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            sub_q      <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            sub_q      <= sub_d;
            result_q   <= result_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
        end
    end

    assign idx_onehot = N'(1) << idx_q;
    assign busy       = (state_q != StIdle);
    assign gnt        = busy ? idx_onehot : '0;
    assign done       = (state_q == StResp) ? idx_onehot : '0;
    assign alu_start  = (state_q == StIssue);
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign alu_sub    = sub_q;
    assign result     = result_q;
    assign err        = err_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural adder answers each start pulse,
// expected completions are queued at stimulus time and popped on every done pulse.
module tb_alu_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 32;

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req;
    logic [16*N-1:0] op_a = '0;
    logic [16*N-1:0] op_b = '0;
    logic [N-1:0]    op_sub = '0;
    logic [N-1:0]    gnt, done;
    logic [15:0]     result, alu_in1, alu_in2, op_count;
    logic            err, busy, alu_sub, alu_start;
    logic [15:0]     alu_out = '0;
    logic            alu_finish = 1'b0;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        e;
    int          pending[N];
    logic [15:0] exp_count = '0;
    int          fin_delay = 1;
    bit          use_fixed = 0;
    logic [15:0] fixed_val = '0;
    int          wc = 0;
    int          lat = 0;
    int          last_lat = 0;
    int          start_count = 0;

    alu_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .gnt       (gnt),
        .done      (done),
        .result    (result),
        .err       (err),
        .busy      (busy),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_sub   (alu_sub),
        .alu_start (alu_start),
        .alu_out   (alu_out),
        .alu_finish(alu_finish),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req[i] = (pending[i] != 0);
    end

    // Behavioural adder: finishes on WAIT cycle fin_delay (0 = never).
    always @(negedge clk) begin
        alu_finish = 1'b0;
        if (wc != 0) begin
            if (wc == fin_delay) begin
                alu_finish = 1'b1;
                wc = 0;
            end else begin
                wc++;
            end
        end
        if (alu_start) begin
            wc = 1;
            alu_out = use_fixed ? fixed_val : (alu_sub ? alu_in1 - alu_in2 : alu_in1 + alu_in2);
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (alu_start) begin
            lat = 0;
            start_count++;
        end else begin
            lat++;
        end
        if (!reset && done !== '0) begin
            last_lat = lat;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done done=%b result=%h err=%b", done, result, err);
            end else begin
                e = sb.pop_front();
                if (done !== (4'b0001 << e.idx) || result !== e.res || err !== e.err) begin
                    errors++;
                    $display("FAIL done_pulse got done=%b result=%h err=%b want done=%b result=%h err=%b",
                             done, result, err, 4'b0001 << e.idx, e.res, e.err);
                end
                checks++;
                if (op_count !== exp_count) begin
                    errors++;
                    $display("FAIL op_count_at_done got %h want %h", op_count, exp_count);
                end
                if (!e.err && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            end
            for (int i = 0; i < N; i++) begin
                if (done[i] && pending[i] > 0) pending[i]--;
            end
        end
    end

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic s);
        op_a[16*i +: 16] = a;
        op_b[16*i +: 16] = b;
        op_sub[i] = s;
    endtask

    task automatic wait_drain(input int max_cyc, output bit ok);
        ok = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
        if (!ok) begin
            sb.delete();
            for (int i = 0; i < N; i++) pending[i] = 0;
        end
    endtask

    task automatic clear_env();
        sb.delete();
        for (int i = 0; i < N; i++) pending[i] = 0;
        exp_count = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_env();
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== '0 || done !== '0 || busy !== 1'b0 || alu_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got gnt=%b done=%b busy=%b start=%b want all zero",
                     gnt, done, busy, alu_start);
        end
        checks++;
        if (result !== '0 || err !== 1'b0 || op_count !== '0) begin
            errors++;
            $display("FAIL reset_status got result=%h err=%b op_count=%h want 0/0/0",
                     result, err, op_count);
        end
        checks++;
        if (alu_in1 !== '0 || alu_in2 !== '0 || alu_sub !== 1'b0) begin
            errors++;
            $display("FAIL reset_operands got in1=%h in2=%h sub=%b want 0", alu_in1, alu_in2,
                     alu_sub);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        bit ok;
        int starts0;
        starts0 = start_count;
        fin_delay = 2;
        set_ops(0, 16'd100, 16'd23, 1'b0);
        sb.push_back('{idx: 0, res: 16'd123, err: 1'b0});
        pending[0] = 1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || alu_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL issue_cycle got gnt=%b start=%b busy=%b want 0001/1/1", gnt,
                     alu_start, busy);
        end
        checks++;
        if (alu_in1 !== 16'd100 || alu_in2 !== 16'd23 || alu_sub !== 1'b0) begin
            errors++;
            $display("FAIL issue_operands got %0d/%0d/%b want 100/23/0", alu_in1, alu_in2,
                     alu_sub);
        end
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_op_drain got no done want done within 20 cycles");
        end
        checks++;
        if (start_count - starts0 != 1 || last_lat != 3) begin
            errors++;
            $display("FAIL single_op_timing got starts=%0d latency=%0d want 1/3",
                     start_count - starts0, last_lat);
        end
        checks++;
        if (op_count !== 16'd1 || result !== 16'd123 || err !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL single_op_after got op_count=%0d result=%0d err=%b gnt=%b want 1/123/0/0",
                     op_count, result, err, gnt);
        end
    endtask

    task automatic test_subtract();
        bit ok;
        fin_delay = 1;
        set_ops(2, 16'd5, 16'd7, 1'b1);
        sb.push_back('{idx: 2, res: 16'hFFFE, err: 1'b0});
        pending[2] = 1;
        wait_drain(20, ok);
        checks++;
        if (!ok || op_count !== 16'd2) begin
            errors++;
            $display("FAIL subtract got drained=%0d op_count=%0d want 1/2", ok, op_count);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        logic [15:0] a, b;
        test_reset();
        fin_delay = 3;
        for (int i = 0; i < N; i++) set_ops(i, 16'(i * 10 + 1), 16'(i + 200), 1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                a = 16'(i * 10 + 1);
                b = 16'(i + 200);
                sb.push_back('{idx: i, res: a + b, err: 1'b0});
            end
        end
        for (int i = 0; i < N; i++) pending[i] = 2;
        wait_drain(100, ok);
        checks++;
        if (!ok || op_count !== 16'd8) begin
            errors++;
            $display("FAIL fairness got drained=%0d op_count=%0d want 1/8", ok, op_count);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        fin_delay = 0;
        set_ops(1, 16'd9, 16'd9, 1'b0);
        set_ops(2, 16'd40, 16'd2, 1'b0);
        sb.push_back('{idx: 1, res: 16'd0, err: 1'b1});
        sb.push_back('{idx: 2, res: 16'd42, err: 1'b0});
        pending[1] = 1;
        pending[2] = 1;
        ok = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (sb.size() < 2) begin
                ok = 1;
                break;
            end
        end
        fin_delay = 1;
        checks++;
        if (!ok || last_lat != TIMEOUT + 1 || op_count !== 16'd8) begin
            errors++;
            $display("FAIL timeout got seen=%0d latency=%0d op_count=%0d want 1/%0d/8", ok,
                     last_lat, op_count, TIMEOUT + 1);
        end
        wait_drain(20, ok);
        checks++;
        if (!ok || op_count !== 16'd9) begin
            errors++;
            $display("FAIL timeout_next got drained=%0d op_count=%0d want 1/9", ok, op_count);
        end
    endtask

    task automatic test_coincide();
        bit ok;
        fin_delay = TIMEOUT;
        use_fixed = 1;
        fixed_val = 16'h7FFF;
        set_ops(3, 16'd1, 16'd1, 1'b0);
        sb.push_back('{idx: 3, res: 16'h7FFF, err: 1'b0});
        pending[3] = 1;
        wait_drain(60, ok);
        use_fixed = 0;
        fin_delay = 1;
        checks++;
        if (!ok || last_lat != TIMEOUT + 1 || op_count !== 16'd10) begin
            errors++;
            $display("FAIL coincide got drained=%0d latency=%0d op_count=%0d want 1/%0d/10", ok,
                     last_lat, op_count, TIMEOUT + 1);
        end
    endtask

    task automatic test_midop();
        bit ok;
        fin_delay = 5;
        set_ops(1, 16'd1000, 16'd1, 1'b0);
        sb.push_back('{idx: 1, res: 16'd1001, err: 1'b0});
        pending[1] = 1;
        ok = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (alu_start) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        op_a[16 +: 16] = 16'hDEAD;
        pending[1] = 0;
        @(negedge clk);
        checks++;
        if (!ok || alu_in1 !== 16'd1000 || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL midop_hold got started=%0d in1=%h gnt=%b want 1/03e8/0010", ok,
                     alu_in1, gnt);
        end
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midop_done got no done want done on requester 1");
        end

        // Abandon an operation with reset while it waits on the adder.
        fin_delay = 0;
        set_ops(3, 16'd77, 16'd3, 1'b1);
        pending[3] = 1;
        ok = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (alu_start) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_env();
        #1;
        checks++;
        if (!ok || busy !== 1'b0 || gnt !== '0 || done !== '0 || op_count !== '0
            || result !== '0 || alu_in1 !== '0) begin
            errors++;
            $display("FAIL reset_in_wait got busy=%b gnt=%b done=%b op_count=%h result=%h in1=%h",
                     busy, gnt, done, op_count, result, alu_in1);
        end
        @(negedge clk);
        reset = 1'b0;
        fin_delay = 1;
        set_ops(0, 16'd11, 16'd4, 1'b1);
        sb.push_back('{idx: 0, res: 16'd7, err: 1'b0});
        sb.push_back('{idx: 3, res: 16'd74, err: 1'b0});
        pending[0] = 1;
        pending[3] = 1;
        wait_drain(30, ok);
        checks++;
        if (!ok || op_count !== 16'd2) begin
            errors++;
            $display("FAIL post_reset_order got drained=%0d op_count=%0d want 1/2", ok, op_count);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        force dut.op_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.op_count_q;
        exp_count = 16'hFFFE;
        @(negedge clk);
        checks++;
        if (op_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL preload got %h want fffe", op_count);
        end
        fin_delay = 2;
        set_ops(2, 16'hFFFF, 16'd2, 1'b0);
        for (int r = 0; r < 3; r++) sb.push_back('{idx: 2, res: 16'd1, err: 1'b0});
        pending[2] = 3;
        wait_drain(40, ok);
        checks++;
        if (!ok || op_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation got drained=%0d op_count=%h want 1/ffff", ok, op_count);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) pending[i] = 0;
        test_reset();
        test_single_op();
        test_subtract();
        test_fairness();
        test_timeout();
        test_coincide();
        test_midop();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion want finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 32, meaning the maximum WAIT cycles before abort (>=2).
REQ-003 Port clk  input  1  system clock, all state on posedge.
REQ-004 Port reset  input  1  reset, asynchronous and active-high.
REQ-005 Port req  input  N  per-requester request level, held high until its done pulse.
REQ-006 Port op_a  input  16*N  operand 1 per requester; slice i is [16i+15:16i].
REQ-007 Port op_b  input  16*N  operand 2 per requester, same slicing.
REQ-008 Port op_sub  input  N  per-requester subtract select (1=sub, 0=add).
REQ-009 Port gnt  output  N  one-hot grant, high while the requester owns the ALU.
REQ-010 Port done  output  N  one-cycle completion pulse to the granted requester.
REQ-011 Port result  output  16  result for the current done pulse, held until the next done.
REQ-012 Port err  output  1  timeout flag qualifying done, held with result.
REQ-013 Port busy  output  1  high in any state other than IDLE.
REQ-014 Port alu_in1 / alu_in2  output  16 each  latched operands to the shared adder.
REQ-015 Port alu_sub  output  1  latched subtract select to the adder.
REQ-016 Port alu_start  output  1  one-cycle start pulse to the adder.
REQ-017 Port alu_out  input  16  adder result.
REQ-018 Port alu_finish  input  1  adder completion, sampled only in WAIT.
REQ-019 Port op_count  output  16  count of completed non-error operations, saturating at 16'hFFFF.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: if any req bit is high, pick the winner round-robin, latch its op_a/op_b/op_sub into alu_in1/alu_in2/alu_sub, set gnt one-hot, go to ISSUE; else stay.
REQ-022 Round-robin search starts at index (last+1) mod N and ascends with wrap; last is the index of the most recent RESP.
REQ-023 ISSUE: alu_start=1 for exactly this cycle, clear the wait counter, go to WAIT.
REQ-024 WAIT: if alu_finish=1, capture alu_out into result, set err=0, go to RESP.
REQ-025 WAIT without finish: increment the counter; on the cycle the counter equals TIMEOUT-1, set result=0 and err=1, go to RESP.
REQ-026 If alu_finish and the timeout coincide in the same cycle, finish SHALL win (err=0).
REQ-027 RESP: done[gnt index]=1 for one cycle, last<=gnt index, and op_count increments (saturating) only if err=0; go to IDLE.
REQ-028 gnt SHALL be high from the ISSUE cycle through the RESP cycle inclusive, and zero in IDLE.
REQ-029 alu_in1/alu_in2/alu_sub SHALL be stable from ISSUE through RESP; operand or req changes after the grant are ignored.
REQ-030 A req deasserted mid-operation SHALL NOT abort the operation; done is still pulsed.
REQ-031 alu_finish in IDLE, ISSUE or RESP SHALL be ignored.
REQ-032 Minimum issue-to-issue spacing is 4 cycles (IDLE, ISSUE, WAIT, RESP); a requester re-raising req immediately after done competes fairly in the next IDLE.
REQ-033 Arithmetic is performed entirely by the adder; the block passes 16-bit values unmodified.

Reset
REQ-034 Reset SHALL force state=IDLE, gnt=0, done=0, alu_start=0, busy=0, err=0, result=0, alu_in1=0, alu_in2=0, alu_sub=0, op_count=0, wait counter=0, last=N-1 (requester 0 has first priority).
REQ-035 Reset during ISSUE/WAIT/RESP SHALL abandon the operation with no done pulse; the first grant after release is chosen as in REQ-034.

Verification
REQ-036 Single op: req=0001, op_a[0]=100, op_b[0]=23, sub=0; adder finishes on WAIT cycle 2 with 123 -> alu_start once, done=0001 for one cycle, result=123, err=0, op_count=1.
REQ-037 Fairness: req=1111 held continuously for 8 operations -> grant order 0,1,2,3,0,1,2,3, no requester starved.
REQ-038 Timeout: alu_finish tied low, TIMEOUT=32 -> done after WAIT cycle 32 with result=0, err=1, op_count unchanged, then grant moves to the next requester.
REQ-039 Coincidence: alu_finish=1 on the timeout cycle with alu_out=16'h7FFF -> err=0, result=16'h7FFF.
REQ-040 Mid-op stress: change op_a[1] and drop req[1] during WAIT -> alu_in1 unchanged, done[1] still pulses; asserting reset in WAIT -> all outputs per REQ-034, no done, next grant goes to requester 0.
REQ-041 Saturation: preload 16'hFFFE completions via 2 extra ops from a forced state -> op_count stops at 16'hFFFF.
